core_dbg_apb_master: RTL and testbench
======================================

Name: core_dbg_apb_master

Overview:
APB4 requester (master) for the core debug path. It turns single debug access requests (valid/ready, clk domain) into APB SETUP/ACCESS transfers. It returns read data, the slave error flag and a timeout flag through a response handshake. It sits between the JTAG debug transport logic and the APB bus that carries the core debug slaves. At most one transfer is outstanding.

Parameters:
ADDR_WIDTH, 32, width of paddr and req_addr
DATA_WIDTH, 32, width of pwdata, prdata, req_wdata and rsp_rdata; must be a multiple of 8
TIMEOUT_CYCLES, 256, ACCESS-phase wait cycles allowed before abort; 0 disables the timeout; maximum 65535

Ports:
clk  in  1  single clock; all APB transfers are timed on its rising edge
rst_n  in  1  reset, asynchronous assert, active-low
req_valid  in  1  debug request present
req_ready  out  1  request accepted when high together with req_valid
req_wr  in  1  1=write, 0=read
req_addr  in  ADDR_WIDTH  target address
req_wdata  in  DATA_WIDTH  write data
req_wstrb  in  DATA_WIDTH/8  write byte enables
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed
rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and for errored transfers
rsp_err  out  1  pslverr seen, or timeout
rsp_timeout  out  1  transfer aborted by the timeout
paddr  out  ADDR_WIDTH  APB address
psel  out  1  APB select
penable  out  1  APB enable
pwrite  out  1  APB direction
pwdata  out  DATA_WIDTH  APB write data
pstrb  out  DATA_WIDTH/8  APB write strobes
pready  in  1  slave ready
prdata  in  DATA_WIDTH  slave read data
pslverr  in  1  slave error

Behaviour:
- Reset (asynchronous, immediate): state=IDLE; psel=penable=pwrite=0; paddr, pwdata, pstrb, rsp_rdata=0; rsp_valid, rsp_err, rsp_timeout=0; wait counter=0.
- A reset during an active transfer drops psel/penable at once. The transfer is lost and no response is produced.
- Every output is driven from a flop, except req_ready, which decodes state==IDLE.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid: latch paddr=req_addr, pwrite=req_wr, pwdata=req_wdata.
  - Also latch pstrb=req_wstrb for writes, or 0 for reads (APB4 rule).
  - Next state SETUP.
- SETUP: psel=1, penable=0 for exactly one cycle. Next state ACCESS.
- ACCESS:
  - psel=1, penable=1.
  - paddr, pwrite, pwdata and pstrb stay stable until the transfer completes.
  - Each cycle with pready=0 increments the wait counter.
- Normal completion, on a cycle with pready=1:
  - Set rsp_err=pslverr and rsp_timeout=0.
  - Set rsp_rdata=prdata when the transfer is a read and pslverr=0; otherwise rsp_rdata=0.
  - Next cycle psel=penable=0 and rsp_valid=1; state RESP.
- Timeout abort: TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES while pready=0.
  - Next cycle psel=penable=0, rsp_err=1, rsp_timeout=1, rsp_rdata=0; state RESP.
  - A pready that arrives on the abort cycle itself wins: the transfer completes normally.
- RESP: rsp_valid=1 and response fields stay stable until rsp_ready. On rsp_ready: rsp_valid=0, counter=0, state IDLE.
- Latency: accept at cycle N, SETUP at N+1, ACCESS at N+2. With a zero-wait slave, rsp_valid=1 at N+3. If rsp_ready is already high, the next request can be accepted at N+4.
- Throughput: one transfer per 4 cycles minimum.
- APB outputs hold their last values in IDLE and RESP, apart from psel/penable, which are 0.
- req_valid is ignored outside IDLE.
- Wait counter: 16 bits, saturates, cleared on every SETUP entry.

Decomposition:
- Package core_dbg_apb_pkg holds:
  - the FSM state enum (2 bits: IDLE=0, SETUP=1, ACCESS=2, RESP=3);
  - the response struct {rdata, err, timeout};
  - localparam STRB_W = DATA_WIDTH/8.
- One sub-module, apb_wait_timer, holds the counter and the expired compare. Inputs: clear, count enable, limit, disable-when-zero. Output: expired.

Test Plan:
- Zero-wait read: req addr=0x40 rd; slave returns pready=1, prdata=0xDEADBEEF. Required: psel at N+1, penable at N+2, rsp_valid at N+3, rsp_rdata=0xDEADBEEF, rsp_err=0, pstrb=0.
- Write with 3 wait states: addr=0x44, wdata=0x12345678, wstrb=0x3. Required: paddr, pwdata, pstrb=0x3 and pwrite=1 held stable for 4 ACCESS cycles; rsp_rdata=0; rsp_err=0.
- Slave error on read: pslverr=1, prdata=0xFFFF. Required: rsp_err=1, rsp_timeout=0, rsp_rdata=0.
- Timeout with TIMEOUT_CYCLES=4 and pready held 0. Required: abort after 4 ACCESS wait cycles; psel drops; rsp_err=1, rsp_timeout=1.
  - Rerun with pready=1 on the abort cycle: required normal completion.
- Response backpressure: rsp_ready=0 for 5 cycles. Required: rsp fields stable, req_ready=0, a new req_valid is not accepted; the second request is accepted the cycle after rsp_ready=1.
- Asynchronous reset asserted mid-ACCESS. Required: psel, penable and rsp_valid go 0 without waiting for a clk edge. After release, a read to 0x40 completes with normal latency.

Source files
------------

// File: rtl/core_dbg_apb_master_pkg.sv
// Shared types and constants for the core debug APB requester.
//   - apb_state_e : requester FSM encoding (IDLE/SETUP/ACCESS/RESP)
//   - apb_rsp_t   : response record {rdata, err, timeout}
//   - STRB_W      : byte-strobe width for the default data width
//   - complete_rsp: builds the response of a transfer that saw pready=1
package core_dbg_apb_pkg;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;
    localparam int STRB_W     = APB_DATA_W / 8;
    localparam int WAIT_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_e;

    typedef struct packed {
        logic [APB_DATA_W-1:0] rdata;
        logic                  err;
        logic                  timeout;
    } apb_rsp_t;

    // Read data is only returned for error-free reads; writes and errors return zero.
    function automatic apb_rsp_t complete_rsp(
        input logic                  is_write,
        input logic                  slverr,
        input logic [APB_DATA_W-1:0] rdata
    );
        apb_rsp_t r;
        r.err     = slverr;
        r.timeout = 1'b0;
        if (!is_write && !slverr) begin
            r.rdata = rdata;
        end else begin
            r.rdata = {APB_DATA_W{1'b0}};
        end
        return r;
    endfunction

endpackage

// File: rtl/core_dbg_apb_master_timer.sv
// ACCESS-phase wait timer.
// Ports: clk, rst_n (async, active-low); clear zeroes the count; count_en adds
// one (saturating at all-ones); limit is the abort threshold; disable_zero makes
// limit==0 mean "never expire"; expired flags the cycle on which the count
// being added would reach the limit.
module apb_wait_timer
    import core_dbg_apb_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  count_en,
    input  logic [WAIT_CNT_W-1:0] limit,
    input  logic                  disable_zero,
    output logic                  expired
);

    logic [WAIT_CNT_W-1:0] cnt_r;
    logic [WAIT_CNT_W-1:0] cnt_inc_s;
    logic                  expired_s;

    // Saturating increment of the wait count.
    always_comb begin
        cnt_inc_s = cnt_r;
        if (cnt_r == {WAIT_CNT_W{1'b1}}) begin
            cnt_inc_s = cnt_r;
        end else begin
            cnt_inc_s = cnt_r + {{(WAIT_CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Expiry is judged on the count this wait cycle produces, so the Nth waited
    // cycle is the abort cycle.
    always_comb begin
        expired_s = 1'b0;
        if (disable_zero && (limit == {WAIT_CNT_W{1'b0}})) begin
            expired_s = 1'b0;
        end else if (count_en) begin
            expired_s = (cnt_inc_s >= limit);
        end else begin
            expired_s = 1'b0;
        end
    end

    // Wait count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {WAIT_CNT_W{1'b0}};
        end else if (clear) begin
            cnt_r <= {WAIT_CNT_W{1'b0}};
        end else if (count_en) begin
            cnt_r <= cnt_inc_s;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expired = expired_s;

endmodule

// File: rtl/core_dbg_apb_master.sv
// APB4 requester for the core debug path: one debug request at a time becomes
// an APB SETUP/ACCESS transfer; the result comes back on a response handshake.
// Ports: req_* (request valid/ready, direction, address, data, strobes),
// rsp_* (response valid/ready, read data, error, timeout), p* (APB4 requester).
// All outputs are flops except req_ready, which decodes the IDLE state.
// The response record is sized by the package data width, so DATA_WIDTH must
// stay equal to APB_DATA_W.
module core_dbg_apb_master
    import core_dbg_apb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_wr,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_wstrb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic                    rsp_timeout,
    output logic [ADDR_WIDTH-1:0]   paddr,
    output logic                    psel,
    output logic                    penable,
    output logic                    pwrite,
    output logic [DATA_WIDTH-1:0]   pwdata,
    output logic [DATA_WIDTH/8-1:0] pstrb,
    input  logic                    pready,
    input  logic [DATA_WIDTH-1:0]   prdata,
    input  logic                    pslverr
);

    localparam logic [WAIT_CNT_W-1:0] TMO_LIMIT = WAIT_CNT_W'(TIMEOUT_CYCLES);

    apb_state_e              state_r, state_s;
    logic                    psel_r, psel_s;
    logic                    penable_r, penable_s;
    logic                    pwrite_r, pwrite_s;
    logic [ADDR_WIDTH-1:0]   paddr_r, paddr_s;
    logic [DATA_WIDTH-1:0]   pwdata_r, pwdata_s;
    logic [DATA_WIDTH/8-1:0] pstrb_r, pstrb_s;
    logic                    rsp_valid_r, rsp_valid_s;
    apb_rsp_t                rsp_r, rsp_s;
    logic                    timer_clr_s;
    logic                    timer_cnt_en_s;
    logic                    timer_expired_s;

    // Count restarts on every accepted request and on every consumed response.
    assign timer_clr_s    = ((state_r == ST_IDLE) && req_valid) ||
                            ((state_r == ST_RESP) && rsp_ready);
    assign timer_cnt_en_s = (state_r == ST_ACCESS) && !pready;

    apb_wait_timer u_wait_timer (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (timer_clr_s),
        .count_en     (timer_cnt_en_s),
        .limit        (TMO_LIMIT),
        .disable_zero (1'b1),
        .expired      (timer_expired_s)
    );

    // Next-state and next-output decode; psel/penable are computed one cycle
    // ahead so they come straight from flops.
    always_comb begin
        state_s     = state_r;
        psel_s      = 1'b0;
        penable_s   = 1'b0;
        pwrite_s    = pwrite_r;
        paddr_s     = paddr_r;
        pwdata_s    = pwdata_r;
        pstrb_s     = pstrb_r;
        rsp_valid_s = rsp_valid_r;
        rsp_s       = rsp_r;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    paddr_s  = req_addr;
                    pwrite_s = req_wr;
                    pwdata_s = req_wdata;
                    // Reads must drive all-zero strobes on APB4.
                    pstrb_s  = req_wr ? req_wstrb : {(DATA_WIDTH/8){1'b0}};
                    psel_s   = 1'b1;
                    state_s  = ST_SETUP;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_SETUP: begin
                psel_s    = 1'b1;
                penable_s = 1'b1;
                state_s   = ST_ACCESS;
            end
            ST_ACCESS: begin
                // pready has priority: the timer never expires on a ready cycle.
                if (pready) begin
                    rsp_s       = complete_rsp(pwrite_r, pslverr, prdata);
                    rsp_valid_s = 1'b1;
                    state_s     = ST_RESP;
                end else if (timer_expired_s) begin
                    rsp_s.rdata   = {APB_DATA_W{1'b0}};
                    rsp_s.err     = 1'b1;
                    rsp_s.timeout = 1'b1;
                    rsp_valid_s   = 1'b1;
                    state_s       = ST_RESP;
                end else begin
                    psel_s    = 1'b1;
                    penable_s = 1'b1;
                    state_s   = ST_ACCESS;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_s = 1'b0;
                    state_s     = ST_IDLE;
                end else begin
                    state_s     = ST_RESP;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            psel_r      <= 1'b0;
            penable_r   <= 1'b0;
            pwrite_r    <= 1'b0;
            paddr_r     <= {ADDR_WIDTH{1'b0}};
            pwdata_r    <= {DATA_WIDTH{1'b0}};
            pstrb_r     <= {(DATA_WIDTH/8){1'b0}};
            rsp_valid_r <= 1'b0;
            rsp_r       <= '{rdata: {APB_DATA_W{1'b0}}, err: 1'b0, timeout: 1'b0};
        end else begin
            state_r     <= state_s;
            psel_r      <= psel_s;
            penable_r   <= penable_s;
            pwrite_r    <= pwrite_s;
            paddr_r     <= paddr_s;
            pwdata_r    <= pwdata_s;
            pstrb_r     <= pstrb_s;
            rsp_valid_r <= rsp_valid_s;
            rsp_r       <= rsp_s;
        end
    end

    assign req_ready   = (state_r == ST_IDLE);
    assign psel        = psel_r;
    assign penable     = penable_r;
    assign pwrite      = pwrite_r;
    assign paddr       = paddr_r;
    assign pwdata      = pwdata_r;
    assign pstrb       = pstrb_r;
    assign rsp_valid   = rsp_valid_r;
    assign rsp_rdata   = rsp_r.rdata;
    assign rsp_err     = rsp_r.err;
    assign rsp_timeout = rsp_r.timeout;

endmodule

// File: tb/tb_core_dbg_apb_master.sv
// Directed bench for core_dbg_apb_master (TIMEOUT_CYCLES=4). Inputs change 1 ns
// after a rising edge and outputs are checked in that same window.
module tb_core_dbg_apb_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_wr;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err, rsp_timeout;
    logic [31:0] paddr, pwdata, prdata;
    logic        psel, penable, pwrite, pready, pslverr;
    logic [3:0]  pstrb;

    int errors = 0;
    int checks = 0;

    core_dbg_apb_master #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
        .pwdata(pwdata), .pstrb(pstrb),
        .pready(pready), .prdata(prdata), .pslverr(pslverr)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_addr = 32'h0;
        req_wdata = 32'h0; req_wstrb = 4'h0; rsp_ready = 1'b0;
        pready = 1'b0; prdata = 32'h0; pslverr = 1'b0;
        #1;
        checks++; if (psel !== 1'b0 || penable !== 1'b0 || pwrite !== 1'b0) begin errors++; $display("FAIL reset_apb_ctrl: got psel=%b penable=%b pwrite=%b want 0 0 0", psel, penable, pwrite); end
        checks++; if (paddr !== 32'h0 || pwdata !== 32'h0 || pstrb !== 4'h0) begin errors++; $display("FAIL reset_apb_data: got paddr=%h pwdata=%h pstrb=%h want zeros", paddr, pwdata, pstrb); end
        checks++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_timeout !== 1'b0 || rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rsp: got v=%b e=%b t=%b d=%h want zeros", rsp_valid, rsp_err, rsp_timeout, rsp_rdata); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
        step(); step();
        rst_n = 1'b1;
        step();
    endtask

    // Zero-wait read issued at cycle N; checks N+1, N+2, N+3 and hands the response back.
    task automatic test_zero_wait_read(input logic [31:0] addr, input logic [31:0] data);
        req_valid = 1'b1; req_wr = 1'b0; req_addr = addr; req_wdata = 32'hA5A5_5A5A; req_wstrb = 4'hF;
        pready = 1'b1; prdata = data; pslverr = 1'b0; rsp_ready = 1'b0;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rd_req_ready: got %b want 1", req_ready); end
        step();
        req_valid = 1'b0;
        checks++; if (psel !== 1'b1 || penable !== 1'b0) begin errors++; $display("FAIL rd_setup: got psel=%b penable=%b want 1 0", psel, penable); end
        checks++; if (paddr !== addr || pwrite !== 1'b0 || pstrb !== 4'h0) begin errors++; $display("FAIL rd_setup_fields: got paddr=%h pwrite=%b pstrb=%h want %h 0 0", paddr, pwrite, pstrb, addr); end
        step();
        checks++; if (psel !== 1'b1 || penable !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL rd_access: got psel=%b penable=%b rsp_valid=%b want 1 1 0", psel, penable, rsp_valid); end
        step();
        checks++; if (rsp_valid !== 1'b1 || psel !== 1'b0 || penable !== 1'b0) begin errors++; $display("FAIL rd_resp: got rsp_valid=%b psel=%b penable=%b want 1 0 0", rsp_valid, psel, penable); end
        checks++; if (rsp_rdata !== data || rsp_err !== 1'b0 || rsp_timeout !== 1'b0) begin errors++; $display("FAIL rd_resp_fields: got d=%h e=%b t=%b want %h 0 0", rsp_rdata, rsp_err, rsp_timeout, data); end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL rd_done: got rsp_valid=%b req_ready=%b want 0 1", rsp_valid, req_ready); end
    endtask

    task automatic test_write_wait();
        req_valid = 1'b1; req_wr = 1'b1; req_addr = 32'h44; req_wdata = 32'h1234_5678; req_wstrb = 4'h3;
        pready = 1'b0; prdata = 32'hFFFF_0000; pslverr = 1'b0;
        step();
        req_valid = 1'b0; req_wdata = 32'h0; req_addr = 32'h0; req_wstrb = 4'h0;
        step();
        for (int i = 0; i < 4; i++) begin
            checks++; if (psel !== 1'b1 || penable !== 1'b1) begin errors++; $display("FAIL wr_access_%0d: got psel=%b penable=%b want 1 1", i, psel, penable); end
            checks++; if (paddr !== 32'h44 || pwdata !== 32'h1234_5678 || pstrb !== 4'h3 || pwrite !== 1'b1) begin errors++; $display("FAIL wr_stable_%0d: got a=%h d=%h s=%h w=%b", i, paddr, pwdata, pstrb, pwrite); end
            pready = (i == 3) ? 1'b1 : 1'b0;
            step();
        end
        checks++; if (rsp_valid !== 1'b1 || psel !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0 || rsp_timeout !== 1'b0) begin errors++; $display("FAIL wr_resp: got v=%b psel=%b d=%h e=%b t=%b want 1 0 0 0 0", rsp_valid, psel, rsp_rdata, rsp_err, rsp_timeout); end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    task automatic test_slave_error();
        req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'h48; req_wstrb = 4'h0;
        pready = 1'b1; prdata = 32'h0000_FFFF; pslverr = 1'b1;
        step();
        req_valid = 1'b0;
        step(); step();
        checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_timeout !== 1'b0 || rsp_rdata !== 32'h0) begin errors++; $display("FAIL slverr_resp: got v=%b e=%b t=%b d=%h want 1 1 0 0", rsp_valid, rsp_err, rsp_timeout, rsp_rdata); end
        pslverr = 1'b0; rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    // late_ready=1 raises pready on the fourth ACCESS cycle, which is the abort cycle.
    task automatic test_timeout(input logic late_ready);
        req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'h4C;
        pready = 1'b0; prdata = 32'h0BAD_F00D; pslverr = 1'b0;
        step();
        req_valid = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            checks++; if (psel !== 1'b1 || penable !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL tmo_access_%0d_%0b: got psel=%b penable=%b v=%b want 1 1 0", i, late_ready, psel, penable, rsp_valid); end
            pready = (i == 3) ? late_ready : 1'b0;
            step();
        end
        pready = 1'b0;
        checks++; if (psel !== 1'b0 || penable !== 1'b0 || rsp_valid !== 1'b1) begin errors++; $display("FAIL tmo_end_%0b: got psel=%b penable=%b v=%b want 0 0 1", late_ready, psel, penable, rsp_valid); end
        if (late_ready) begin
            checks++; if (rsp_err !== 1'b0 || rsp_timeout !== 1'b0 || rsp_rdata !== 32'h0BAD_F00D) begin errors++; $display("FAIL tmo_ready_wins: got e=%b t=%b d=%h want 0 0 0badf00d", rsp_err, rsp_timeout, rsp_rdata); end
        end else begin
            checks++; if (rsp_err !== 1'b1 || rsp_timeout !== 1'b1 || rsp_rdata !== 32'h0) begin errors++; $display("FAIL tmo_abort: got e=%b t=%b d=%h want 1 1 0", rsp_err, rsp_timeout, rsp_rdata); end
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'h50;
        pready = 1'b1; prdata = 32'h1122_3344; pslverr = 1'b0; rsp_ready = 1'b0;
        step();
        req_valid = 1'b0;
        step(); step();
        req_valid = 1'b1; req_wr = 1'b1; req_addr = 32'h54; req_wdata = 32'hCAFE_F00D; req_wstrb = 4'hF;
        for (int i = 0; i < 5; i++) begin
            checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h1122_3344 || rsp_err !== 1'b0) begin errors++; $display("FAIL bp_hold_%0d: got v=%b d=%h e=%b want 1 11223344 0", i, rsp_valid, rsp_rdata, rsp_err); end
            checks++; if (req_ready !== 1'b0 || psel !== 1'b0 || paddr !== 32'h50) begin errors++; $display("FAIL bp_block_%0d: got rdy=%b psel=%b paddr=%h want 0 0 50", i, req_ready, psel, paddr); end
            step();
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_release: got rdy=%b v=%b want 1 0", req_ready, rsp_valid); end
        step();
        req_valid = 1'b0;
        checks++; if (psel !== 1'b1 || paddr !== 32'h54 || pwrite !== 1'b1 || pstrb !== 4'hF || pwdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL bp_second: got psel=%b a=%h w=%b s=%h d=%h", psel, paddr, pwrite, pstrb, pwdata); end
        step(); step();
        checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0) begin errors++; $display("FAIL bp_second_resp: got v=%b d=%h want 1 0", rsp_valid, rsp_rdata); end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'h60;
        pready = 1'b0; prdata = 32'h0;
        step();
        req_valid = 1'b0;
        step(); step();
        checks++; if (psel !== 1'b1 || penable !== 1'b1) begin errors++; $display("FAIL arst_pre: got psel=%b penable=%b want 1 1", psel, penable); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (psel !== 1'b0 || penable !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL arst_drop: got psel=%b penable=%b v=%b rdy=%b want 0 0 0 1", psel, penable, rsp_valid, req_ready); end
        step();
        checks++; if (rsp_valid !== 1'b0 || psel !== 1'b0) begin errors++; $display("FAIL arst_hold: got v=%b psel=%b want 0 0", rsp_valid, psel); end
        #2;
        rst_n = 1'b1;
        step();
        test_zero_wait_read(32'h40, 32'h55AA_55AA);
    endtask

    initial begin
        test_reset();
        test_zero_wait_read(32'h40, 32'hDEAD_BEEF);
        test_write_wait();
        test_slave_error();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_backpressure();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
